mmio_timer: RTL
===============

Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral.
- Sits on the CPU data bus as a responder, beside data_ram. It uses the same ce/we/addr/sel/data_i/data_o signalling that data_ram uses.
- Provides a free-running or auto-reloading 32-bit counter, a compare match flag and a level interrupt output to the core.
- Reads are combinational and writes commit on the clock edge, so the core needs no protocol changes.

Parameters:
- BASE_ADDR, 32'h2000_0000, byte base address of the register window; must be 32-byte aligned.
- RESET_COMPARE, 32'hFFFF_FFFF, reset value of the COMPARE register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- ce  input  1  bus access strobe from the core.
- we  input  1  1 = write, 0 = read; meaningful only while ce=1.
- addr  input  32  byte address; decoded on addr[31:5]==BASE_ADDR[31:5], register index addr[4:2].
- sel  input  4  byte-lane enables; sel[i] covers data bits [8i+7:8i].
- data_i  input  32  write data.
- data_o  output  32  read data, combinational.
- irq_o  output  1  level interrupt = STATUS.match & CTRL.irq_en.

Behaviour:
- Register map (offset, name, access):
  - 0x00 CTRL rw: bit0 en, bit1 auto_reload, bit2 irq_en; bits[31:3] read 0.
  - 0x04 COUNT rw.
  - 0x08 COMPARE rw.
  - 0x0C STATUS: bit0 match, write-1-to-clear; other bits read 0.
  - 0x10 PRESCALE: see optional feature.
  - 0x14–0x1C: reserved, read 0, writes ignored.
- Reset values (rst=0, async): CTRL=0, COUNT=0, COMPARE=RESET_COMPARE, STATUS=0, PRESCALE=0, internal prescale counter=0.
  - Outputs during reset: irq_o=0; data_o follows the read rule below.
- Hit = ce & (addr[31:5]==BASE_ADDR[31:5]).
- Read (hit & ~we):
  - data_o = selected register, same cycle, zero latency.
  - sel is ignored on reads.
  - Otherwise data_o = 32'h0.
- Write (hit & we):
  - Applied at the rising edge, per byte lane selected by sel. Unselected bytes are unchanged.
  - STATUS write: match is cleared iff sel[0] & data_i[0].
  - addr[1:0] is ignored.
- Tick: asserted for one cycle when CTRL.en=1 and the prescaler expires. Without the optional feature, tick = CTRL.en every cycle.
- On tick:
  - If COUNT==COMPARE: STATUS.match <= 1, and COUNT <= 0 if auto_reload else COUNT+1.
  - Else COUNT <= COUNT+1.
  - 32'hFFFF_FFFF+1 wraps to 0 with no flag.
- Priorities in the same cycle:
  - Bus write to COUNT beats the tick increment/reload. Write data lands per sel; unselected bytes hold their pre-edge value (no increment).
  - Match-set beats W1C clear of STATUS.match.
  - A COMPARE write takes effect from the next cycle's compare. The compare in the write cycle uses the old value.
- irq_o is combinational from the registers: it goes high the cycle after the match edge, and drops the cycle after the W1C edge or irq_en clear.
- Clearing CTRL.en freezes COUNT and the prescale counter. Setting it again resumes without resetting either.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronous), even in the middle of a write cycle.

Optional Feature:
- Macro: MMIO_TIMER_PRESCALE_EN.
- Defined:
  - PRESCALE (0x10, rw, 32-bit, byte-lane writable) and an internal 32-bit prescale counter are present.
  - While en=1: if prescale counter==PRESCALE then tick=1 and the counter resets to 0; otherwise the counter increments.
  - PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE also resets the prescale counter to 0.
- Not defined:
  - No PRESCALE register or prescale counter exist.
  - Offset 0x10 reads 0 and ignores writes.
  - tick = CTRL.en.

Test Plan:
- Reset release, read all offsets -> CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, irq_o=0. A read with ce=0 or an address outside the window -> data_o=0.
- Write COMPARE=5, CTRL=3'b111 (en, auto_reload, irq_en), PRESCALE=0 -> COUNT goes 0..5, then 0. STATUS.match=1 and irq_o=1 from the cycle after COUNT==5. Write STATUS=1 -> irq_o=0 next cycle.
- Write COUNT=32'hFFFF_FFFE with CTRL=1 (free run) and COMPARE=10 -> COUNT reads FFFF_FFFF, then 0, then 1. No match flag set until COUNT==10.
- Byte-lane write: COUNT=32'h1122_3344 with en=0, then write data 32'hAABB_CCDD with sel=4'b0101 -> COUNT=32'h11BB_33DD.
- Simultaneous events:
  - COUNT write 32'h100 in the same cycle as a tick -> COUNT=32'h100 after the edge, not incremented.
  - W1C STATUS in the same cycle as a new match -> match stays 1.
- With MMIO_TIMER_PRESCALE_EN, PRESCALE=3, en=1 -> COUNT increments once every 4 cycles. Without the macro, offset 0x10 reads 0 after a write of 3.

Source files
------------

// File: rtl/mmio_timer_if.sv
// Bus interface for the mmio_timer responder: the same ce/we/addr/sel/data
// signalling the core already uses towards data_ram.
interface mmio_timer_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit timer/compare peripheral.
// Registers: CTRL(0x00) COUNT(0x04) COMPARE(0x08) STATUS(0x0C) PRESCALE(0x10).
// Reads are combinational, writes commit per byte lane at the rising edge.
// Optional prescaler enabled by defining MMIO_TIMER_PRESCALE_EN; without it
// offset 0x10 reads zero and the counter ticks every enabled cycle.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR     = 32'h2000_0000,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    mmio_timer_if.slave bus,
    output logic        irq_o
);
    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_COUNT    = 3'd1;
    localparam logic [2:0] IDX_COMPARE  = 3'd2;
    localparam logic [2:0] IDX_STATUS   = 3'd3;
    localparam logic [2:0] IDX_PRESCALE = 3'd4;

    logic        hit;
    logic        wr_en;
    logic [2:0]  reg_idx;
    logic [31:0] lane_mask;
    logic        tick;
    logic        match_hit;
    logic [31:0] prescale_rd;

    logic [2:0]  ctrl_reg, ctrl_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic        match_reg, match_next;

    assign hit     = bus.ce && (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign wr_en   = hit && bus.we;
    assign reg_idx = bus.addr[4:2];

    // Expand the byte-lane enables into a bit mask for partial writes
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{bus.sel[gi]}};
        end
    endgenerate

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

`ifdef MMIO_TIMER_PRESCALE_EN
    logic [31:0] prescale_reg, prescale_next;
    logic [31:0] pcnt_reg, pcnt_next;

    assign tick        = ctrl_reg[0] && (pcnt_reg == prescale_reg);
    assign prescale_rd = prescale_reg;

    // Prescaler: counts enabled cycles, a PRESCALE write restarts it
    always_comb begin
        prescale_next = prescale_reg;
        pcnt_next     = pcnt_reg;
        if (ctrl_reg[0]) begin
            pcnt_next = tick ? 32'd0 : pcnt_reg + 32'd1;
        end
        if (wr_en && (reg_idx == IDX_PRESCALE)) begin
            prescale_next = merge(prescale_reg, bus.data_i, lane_mask);
            pcnt_next     = 32'd0;
        end
    end

    // Prescaler state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_reg <= 32'd0;
            pcnt_reg     <= 32'd0;
        end else begin
            prescale_reg <= prescale_next;
            pcnt_reg     <= pcnt_next;
        end
    end
`else
    assign tick        = ctrl_reg[0];
    assign prescale_rd = 32'd0;
`endif

    // Next-state: tick advances COUNT, bus writes override it, match beats W1C
    always_comb begin
        match_hit    = tick && (count_reg == compare_reg);
        ctrl_next    = ctrl_reg;
        count_next   = count_reg;
        compare_next = compare_reg;
        match_next   = match_reg;
        if (tick) begin
            count_next = (match_hit && ctrl_reg[1]) ? 32'd0 : count_reg + 32'd1;
        end
        if (wr_en) begin
            case (reg_idx)
                IDX_CTRL:    if (bus.sel[0]) ctrl_next = bus.data_i[2:0];
                IDX_COUNT:   count_next   = merge(count_reg, bus.data_i, lane_mask);
                IDX_COMPARE: compare_next = merge(compare_reg, bus.data_i, lane_mask);
                IDX_STATUS:  if (bus.sel[0] && bus.data_i[0]) match_next = 1'b0;
                default:     ;
            endcase
        end
        if (match_hit) begin
            match_next = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_reg    <= 3'd0;
            count_reg   <= 32'd0;
            compare_reg <= RESET_COMPARE;
            match_reg   <= 1'b0;
        end else begin
            ctrl_reg    <= ctrl_next;
            count_reg   <= count_next;
            compare_reg <= compare_next;
            match_reg   <= match_next;
        end
    end

    // Combinational read mux; zero when not a read hit
    always_comb begin
        bus.data_o = 32'd0;
        if (hit && !bus.we) begin
            case (reg_idx)
                IDX_CTRL:     bus.data_o = {29'd0, ctrl_reg};
                IDX_COUNT:    bus.data_o = count_reg;
                IDX_COMPARE:  bus.data_o = compare_reg;
                IDX_STATUS:   bus.data_o = {31'd0, match_reg};
                IDX_PRESCALE: bus.data_o = prescale_rd;
                default:      bus.data_o = 32'd0;
            endcase
        end
    end

    assign irq_o = match_reg & ctrl_reg[2];
endmodule
